// File: rtl/gumnut_io_pkg.sv
// Shared definitions for the Gumnut I/O timer block:
// register offsets, CTRL bit positions and bus FSM states.
package gumnut_io_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_RELOAD = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_OUT    = 3'd4;

    localparam logic [8:0] REG_SPAN = 9'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    localparam int STATUS_EXP = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } bus_state_t;

    function automatic logic [7:0] ctrl_word(
        input logic en,
        input logic auto_rl,
        input logic ie
    );
        return {5'b00000, ie, auto_rl, en};
    endfunction

endpackage

// File: rtl/gumnut_io_timer_cnt.sv
// Countdown core: COUNT/RELOAD/EN/AUTO state, expiry detect and
// bus-write priority over decrement and reload.
module gumnut_io_timer_cnt
    import gumnut_io_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       wr_ctrl,
    input  logic       wr_reload,
    input  logic       wr_count,
    input  logic [7:0] wdata,
    output logic       en,
    output logic       auto_rl,
    output logic [7:0] count,
    output logic [7:0] reload,
    output logic       expire
);

    logic       en_q;
    logic       en_d;
    logic       auto_q;
    logic       auto_d;
    logic [7:0] count_q;
    logic [7:0] count_d;
    logic [7:0] reload_q;
    logic [7:0] reload_d;

    always_comb begin
        expire = en_q & (count_q == 8'd0);
    end

    always_comb begin
        count_d  = count_q;
        en_d     = en_q;
        auto_d   = auto_q;
        reload_d = reload_q;

        // a bus write to COUNT overrides whatever the timer would do
        if (wr_count) begin
            count_d = wdata;
        end else if (en_q) begin
            if (count_q != 8'd0) begin
                count_d = count_q - 8'd1;
            end else if (auto_q) begin
                count_d = reload_q;
            end else begin
                count_d = 8'd0;
            end
        end

        if (wr_ctrl) begin
            en_d   = wdata[CTRL_EN];
            auto_d = wdata[CTRL_AUTO];
        end else if (expire && !auto_q) begin
            en_d = 1'b0;
        end

        if (wr_reload) begin
            reload_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            count_q  <= 8'd0;
            reload_q <= 8'd0;
        end else if (cen) begin
            en_q     <= en_d;
            auto_q   <= auto_d;
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

    assign en      = en_q;
    assign auto_rl = auto_q;
    assign count   = count_q;
    assign reload  = reload_q;

endmodule

// File: rtl/gumnut_io_timer.sv
// Gumnut I/O-port responder: bus FSM with wait states, register
// decode, expiry status / interrupt request and the output latch.
module gumnut_io_timer #(
    parameter logic [7:0] BASE_ADDR   = 8'h10,
    parameter int         WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [7:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    output logic       int_req_o,
    input  logic       int_ack_i,
    output logic [7:0] out_port_o
);

    import gumnut_io_pkg::*;

    bus_state_t state_q;
    bus_state_t state_d;
    logic [2:0] wait_q;
    logic [2:0] wait_d;

    logic       req;
    logic       hit;
    logic [8:0] adr_ext;
    logic [8:0] base_ext;
    logic [2:0] off;
    logic       in_ack;
    logic       commit;

    logic       wr_ctrl;
    logic       wr_reload;
    logic       wr_count;
    logic       wr_status;
    logic       wr_out;

    logic       t_en;
    logic       t_auto;
    logic [7:0] t_count;
    logic [7:0] t_reload;
    logic       t_expire;

    logic       ie_q;
    logic       exp_q;
    logic       irq_q;
    logic [7:0] out_q;
    logic [7:0] rdata;

    // widen before comparing so a base near 8'hFF cannot wrap
    assign adr_ext  = {1'b0, adr_i};
    assign base_ext = {1'b0, BASE_ADDR};
    assign hit      = (adr_ext >= base_ext) &&
                      (adr_ext <= base_ext + REG_SPAN);
    assign off      = 3'(adr_i - BASE_ADDR);
    assign req      = cyc_i & stb_i;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                        wait_d  = 3'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (wait_q == 3'd0) begin
                    state_d = ACK;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            wait_q  <= 3'd0;
        end else if (cen) begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign in_ack = (state_q == ACK);
    assign commit = in_ack & cen & hit & we_i;

    assign wr_ctrl   = commit && (off == OFF_CTRL);
    assign wr_reload = commit && (off == OFF_RELOAD);
    assign wr_count  = commit && (off == OFF_COUNT);
    assign wr_status = commit && (off == OFF_STATUS);
    assign wr_out    = commit && (off == OFF_OUT);

    gumnut_io_timer_cnt u_cnt (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .wr_ctrl   (wr_ctrl),
        .wr_reload (wr_reload),
        .wr_count  (wr_count),
        .wdata     (dat_i),
        .en        (t_en),
        .auto_rl   (t_auto),
        .count     (t_count),
        .reload    (t_reload),
        .expire    (t_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            ie_q  <= 1'b0;
            exp_q <= 1'b0;
            irq_q <= 1'b0;
            out_q <= 8'd0;
        end else if (cen) begin
            if (wr_ctrl) begin
                ie_q <= dat_i[CTRL_IE];
            end
            // expiry wins over both ways of clearing EXP
            if (t_expire) begin
                exp_q <= 1'b1;
            end else if ((wr_status && dat_i[STATUS_EXP]) || int_ack_i) begin
                exp_q <= 1'b0;
            end
            irq_q <= exp_q & ie_q;
            if (wr_out) begin
                out_q <= dat_i;
            end
        end
    end

    always_comb begin
        rdata = 8'd0;
        if (in_ack && hit) begin
            case (off)
                OFF_CTRL:   rdata = ctrl_word(t_en, t_auto, ie_q);
                OFF_RELOAD: rdata = t_reload;
                OFF_COUNT:  rdata = t_count;
                OFF_STATUS: rdata = {7'd0, exp_q};
                OFF_OUT:    rdata = out_q;
                default:    rdata = 8'd0;
            endcase
        end
    end

    assign dat_o      = rdata;
    assign ack_o      = in_ack;
    assign int_req_o  = irq_q;
    assign out_port_o = out_q;

endmodule
